// File: rtl/minimig_eclk_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : minimig_eclk_pkg
//  Description : Shared definitions for E-clock consumers: bus-sequencer
//                state encoding, E phase landmarks and the one-hot eclk to
//                phase index encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package minimig_eclk_pkg;

  // Synchronous (6800-style) bus cycle sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_VMA       = 3'd2,
    ST_E_HI      = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  localparam int E_PHASES   = 10;  // 7MHz periods per E period
  localparam int E_HI_FIRST = 6;   // first phase with E high
  localparam int E_LAST     = 9;   // last phase of the E period

  // One-hot to index. On a malformed vector the highest set bit wins; callers
  // gate on the separate one-hot check, so that value is never acted upon.
  function automatic logic [3:0] eclk_index(input logic [E_PHASES-1:0] eclk);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < E_PHASES; i++) begin
      if (eclk[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eclk_phase_dec.sv
`default_nettype none
// ============================================================================
//  Module      : eclk_phase_dec
//  Description : Decodes the one-hot eclk phase enables into a phase index,
//                checks that the vector is one-hot and registers E itself.
//  Revision    : 1.0  initial release
//  Ports       : i_clk        28MHz clock
//                i_rst_n      asynchronous reset, active low
//                i_eclk       one-hot E phase enables
//                o_phase      encoded phase index (combinational)
//                o_onehot_ok  exactly one eclk bit set (combinational)
//                o_e_out      registered E clock, high during phases 6..9
// ============================================================================
module eclk_phase_dec
  import minimig_eclk_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [E_PHASES-1:0] i_eclk,
  output logic [3:0]          o_phase,
  output logic                o_onehot_ok,
  output logic                o_e_out
);

  logic r_e_out;

  assign o_phase     = eclk_index(i_eclk);
  // x & (x-1) clears the lowest set bit: zero afterwards means at most one bit
  assign o_onehot_ok = (i_eclk != '0) &&
                       ((i_eclk & (i_eclk - 10'd1)) == '0);

  // E follows the phase stream every clk_28 cycle, independent of clk7_en
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_e_out <= 1'b0;
    else          r_e_out <= |i_eclk[E_LAST:E_HI_FIRST];
  end

  assign o_e_out = r_e_out;

endmodule
`default_nettype wire

// File: rtl/eclk_bus_seq.sv
`default_nettype none
// ============================================================================
//  Module      : eclk_bus_seq
//  Description : Sequences VPA/VMA synchronous peripheral cycles in step with
//                the E clock phase enables, between the CPU bus bridge and
//                the peripheral strobes. Flags malformed eclk and stalled
//                synchronisation.
//  Revision    : 1.0  initial release
//  Ports       : i_clk (clk_28)      28MHz clock
//                i_rst_n (_rst)      asynchronous reset, active low
//                i_clk7_en           7MHz enable, all FSM state advances on it
//                i_eclk[9:0]         one-hot E phase enables
//                i_req, i_rw, i_wdat CPU request (held until ack), direction,
//                                    write data
//                i_pdat_in           peripheral read data
//                o_e_out             E clock
//                o_vma, o_prw        peripheral address-valid and direction
//                o_pdat_out          registered write data
//                o_rdat              latched read data, valid with ack
//                o_ack               one-clk_28 completion pulse
//                o_err_tmo           sticky: synchronisation timed out
//                o_err_phase         sticky: eclk not one-hot on clk7_en
// ============================================================================
module eclk_bus_seq
  import minimig_eclk_pkg::*;
#(
  parameter int DW      = 16,
  parameter int LATE_PH = 2,
  parameter int TMO_E   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clk7_en,
  input  logic [E_PHASES-1:0] i_eclk,
  input  logic                i_req,
  input  logic                i_rw,
  input  logic [DW-1:0]       i_wdat,
  input  logic [DW-1:0]       i_pdat_in,
  output logic                o_e_out,
  output logic                o_vma,
  output logic                o_prw,
  output logic [DW-1:0]       o_pdat_out,
  output logic [DW-1:0]       o_rdat,
  output logic                o_ack,
  output logic                o_err_tmo,
  output logic                o_err_phase
);

  localparam int                c_cnt_w    = $clog2(TMO_E + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TMO_E - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_max  = c_cnt_w'(TMO_E);

  state_t               r_state, w_next;
  logic [c_cnt_w-1:0]   r_tmo_cnt;
  logic                 r_vma, r_prw, r_ack, r_err_tmo, r_err_phase, r_drop;
  logic [DW-1:0]        r_pdat_out, r_rdat;

  logic [3:0]           w_phase;
  logic                 w_onehot_ok, w_step;
  logic                 w_capture, w_cnt_inc, w_tmo, w_drop_set, w_rd_latch, w_ack;

  eclk_phase_dec u_phase_dec (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_eclk      (i_eclk),
    .o_phase     (w_phase),
    .o_onehot_ok (w_onehot_ok),
    .o_e_out     (o_e_out)
  );

  // A malformed phase vector freezes the sequencer for that period
  assign w_step = i_clk7_en && w_onehot_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_tmo      = 1'b0;
    w_drop_set = 1'b0;
    w_rd_latch = 1'b0;
    w_ack      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_step && i_req) begin
          w_capture = 1'b1;
          // Early enough to fit VMA plus E-high into the current E period
          w_next    = (w_phase <= 4'(LATE_PH)) ? ST_VMA : ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (w_step) begin
          if (!i_req) begin
            w_next = ST_IDLE;                    // nothing committed yet
          end else if (i_eclk[0]) begin
            w_next = ST_VMA;
          end else if (i_eclk[E_LAST]) begin
            if (r_tmo_cnt == c_tmo_last) begin
              w_tmo  = 1'b1;
              w_next = ST_IDLE;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
      end
      ST_VMA: begin
        if (w_step) begin
          w_drop_set = !i_req;
          if (i_eclk[E_HI_FIRST]) w_next = ST_E_HI;
        end
      end
      ST_E_HI: begin
        if (w_step) begin
          w_drop_set = !i_req;
          if (i_eclk[E_LAST]) begin
            w_rd_latch = r_prw;
            w_next     = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        // Leaves after a single clk_28 so ack cannot stretch across the
        // next clk7_en, where a fresh request may be sampled
        w_ack  = !r_drop && !w_drop_set && i_req;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt   <= '0;
      r_vma       <= 1'b0;
      r_prw       <= 1'b0;
      r_pdat_out  <= '0;
      r_rdat      <= '0;
      r_ack       <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_phase <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_vma <= (w_next == ST_VMA) || (w_next == ST_E_HI);
      r_ack <= w_ack;
      if (w_capture) begin
        r_prw      <= i_rw;
        r_pdat_out <= i_wdat;
        r_tmo_cnt  <= '0;
        r_drop     <= 1'b0;
      end else begin
        if (w_cnt_inc && (r_tmo_cnt != c_tmo_max)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (w_drop_set) r_drop <= 1'b1;
      end
      if (w_rd_latch) r_rdat <= i_pdat_in;
      if (w_tmo) r_err_tmo <= 1'b1;
      if (i_clk7_en && !w_onehot_ok) r_err_phase <= 1'b1;
    end
  end

  assign o_vma       = r_vma;
  assign o_prw       = r_prw;
  assign o_pdat_out  = r_pdat_out;
  assign o_rdat      = r_rdat;
  assign o_ack       = r_ack;
  assign o_err_tmo   = r_err_tmo;
  assign o_err_phase = r_err_phase;

endmodule
`default_nettype wire

// File: tb/tb_eclk_bus_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eclk_bus_seq
//  Description : Directed self-checking bench for eclk_bus_seq. A generator
//                process produces clk7_en (last clk_28 of each 7MHz period)
//                and the one-hot eclk stream, with hooks to skip phase 0 and
//                to inject one malformed period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eclk_bus_seq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk7_en = 1'b0;
  logic [9:0]    eclk = 10'd1;
  logic          req = 1'b0;
  logic          rw = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic [DW-1:0] pdat_in = '0;
  logic          e_out, vma, prw, ack, err_tmo, err_phase;
  logic [DW-1:0] pdat_out, rdat;

  int   errors = 0;
  int   checks = 0;

  // phase generator state
  int         sub = 0;
  int         ph = 0;
  bit         skip0 = 1'b0;
  bit         inj_arm = 1'b0;
  int         inj_ph = 0;
  logic [9:0] inj_val = '0;

  // per-cycle observations
  int an, aw, vf, vl, tn;
  bit bb;

  eclk_bus_seq #(.DW(DW), .LATE_PH(2), .TMO_E(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clk7_en   (clk7_en),
    .i_eclk      (eclk),
    .i_req       (req),
    .i_rw        (rw),
    .i_wdat      (wdat),
    .i_pdat_in   (pdat_in),
    .o_e_out     (e_out),
    .o_vma       (vma),
    .o_prw       (prw),
    .o_pdat_out  (pdat_out),
    .o_rdat      (rdat),
    .o_ack       (ack),
    .o_err_tmo   (err_tmo),
    .o_err_phase (err_phase)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge, clear of sampling
  always begin
    @(posedge clk);
    #2;
    sub = (sub + 1) % 4;
    if (sub == 0) begin
      if (ph == 9) ph = skip0 ? 1 : 0;
      else         ph = ph + 1;
      if (inj_arm && ph == inj_ph) begin
        eclk    = inj_val;
        inj_arm = 1'b0;
      end else begin
        eclk = 10'd1 << ph;
      end
    end
    clk7_en = (sub == 3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just before the clk7_en edge closing phase p
  task automatic wait_end(input int p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (clk7_en && ph == p) return;
    end
    checks++;
    errors++;
    $error("FAIL wait_phase_%0d: phase not reached within 200 cycles", p);
  endtask

  // Issues a request at the end of phase p and watches max_n clk_28 cycles.
  // n counts falling edges after the request edge; ack rising k edges after
  // the request edge shows up at n = k + 1.
  task automatic run_cycle(input int p, input logic r, input logic [DW-1:0] wd,
                           input int drop_ph, input int max_n,
                           output int ack_n, output int ack_w, output int vma_first,
                           output int vma_last, output bit bus_bad, output int tmo_n);
    bit dropped;
    ack_n = -1; ack_w = 0; vma_first = -1; vma_last = -1; bus_bad = 1'b0;
    tmo_n = -1; dropped = 1'b0;
    wait_end(p);
    req = 1'b1; rw = r; wdat = wd;
    for (int n = 1; n <= max_n; n++) begin
      @(negedge clk);
      if (ack) begin
        ack_w++;
        if (ack_n < 0) ack_n = n;
        req = 1'b0;
      end
      if (vma) begin
        if (vma_first < 0) vma_first = ph;
        vma_last = ph;
        if (prw !== r || pdat_out !== wd) bus_bad = 1'b1;
      end
      if (err_tmo && tmo_n < 0) begin
        tmo_n = n;
        req   = 1'b0;
      end
      if (!dropped && drop_ph >= 0 && ph == drop_ph && sub == 1) begin
        dropped = 1'b1;
        req     = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    // ---- reset state
    repeat (6) @(negedge clk);
    check("rst_vma", vma, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_rdat", rdat, 16'h0000);
    check("rst_errs", {err_tmo, err_phase}, 2'b00);
    rst_n = 1'b1;

    // ---- E clock output follows phases 6..9
    wait_end(5); check("e_out_ph5", e_out, 1'b0);
    wait_end(6); check("e_out_ph6", e_out, 1'b1);
    wait_end(9); check("e_out_ph9", e_out, 1'b1);
    wait_end(0); check("e_out_ph0", e_out, 1'b0);

    // ---- 1: read, request at phase 1 -> 8 periods + 1 clk_28
    pdat_in = 16'hA55A;
    run_cycle(1, 1'b1, 16'h1111, -1, 60, an, aw, vf, vl, bb, tn);
    check("t1_ack_lat", an, 34);
    check("t1_ack_width", aw, 1);
    check("t1_vma_first", vf, 2);
    check("t1_vma_last", vl, 9);
    check("t1_bus", bb, 1'b0);
    check("t1_rdat", rdat, 16'hA55A);

    // ---- 2: write, request at phase 5 -> WAIT_SYNC, 14 periods + 1 clk_28
    pdat_in = 16'h1234;
    run_cycle(5, 1'b0, 16'hBEEF, -1, 80, an, aw, vf, vl, bb, tn);
    check("t2_ack_lat", an, 58);
    check("t2_ack_width", aw, 1);
    check("t2_vma_first", vf, 1);
    check("t2_vma_last", vl, 9);
    check("t2_bus", bb, 1'b0);
    check("t2_pdat_out", pdat_out, 16'hBEEF);
    check("t2_rdat_kept", rdat, 16'hA55A);

    // ---- LATE_PH boundary: phase 2 joins this E period, phase 3 does not
    pdat_in = 16'h5AA5;
    run_cycle(2, 1'b1, 16'h0000, -1, 50, an, aw, vf, vl, bb, tn);
    check("b2_ack_lat", an, 30);
    check("b2_vma_first", vf, 3);
    check("b2_rdat", rdat, 16'h5AA5);
    run_cycle(3, 1'b0, 16'h7E81, -1, 90, an, aw, vf, vl, bb, tn);
    check("b3_ack_lat", an, 66);
    check("b3_vma_first", vf, 1);
    check("b3_bus", bb, 1'b0);

    // ---- 3: request at phase 3 dropped at phase 7 while waiting for sync
    run_cycle(3, 1'b1, 16'h0000, 7, 90, an, aw, vf, vl, bb, tn);
    check("t3_no_ack", an, -1);
    check("t3_no_vma", vf, -1);

    // ---- 4: request dropped during E high -> cycle completes, no ack
    pdat_in = 16'hC3C3;
    run_cycle(1, 1'b1, 16'h0000, 8, 60, an, aw, vf, vl, bb, tn);
    check("t4_no_ack", an, -1);
    check("t4_vma_first", vf, 2);
    check("t4_vma_last", vl, 9);
    check("t4_rdat", rdat, 16'hC3C3);

    // ---- 5: malformed phase while idle, then during a live cycle
    check("t5_err_phase_pre", err_phase, 1'b0);
    inj_ph = 4; inj_val = 10'b0000000011; inj_arm = 1'b1;
    wait_end(5);
    check("t5_err_phase", err_phase, 1'b1);
    check("t5_idle_vma", vma, 1'b0);
    wait_end(0);
    inj_ph = 4; inj_val = 10'b0000000011; inj_arm = 1'b1;
    pdat_in = 16'h0F0F;
    run_cycle(1, 1'b1, 16'h0000, -1, 60, an, aw, vf, vl, bb, tn);
    check("t5_ack_lat", an, 34);
    check("t5_vma_first", vf, 2);
    check("t5_vma_last", vl, 9);
    check("t5_rdat", rdat, 16'h0F0F);
    check("t5_err_sticky", err_phase, 1'b1);

    // ---- 6: phase 0 never arrives -> timeout after 4 E periods
    check("t6_err_tmo_pre", err_tmo, 1'b0);
    skip0 = 1'b1;
    run_cycle(5, 1'b1, 16'h0000, -1, 140, an, aw, vf, vl, bb, tn);
    check("t6_tmo_time", tn, 125);
    check("t6_no_ack", an, -1);
    check("t6_no_vma", vf, -1);
    check("t6_err_tmo", err_tmo, 1'b1);
    skip0 = 1'b0;

    // ---- reset mid-cycle drops everything without waiting for a clock
    wait_end(1);
    req = 1'b1; rw = 1'b1; wdat = 16'h9999;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vma) break;
    end
    check("r_vma_live", vma, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("r_vma", vma, 1'b0);
    check("r_ack", ack, 1'b0);
    check("r_prw", prw, 1'b0);
    check("r_pdat_out", pdat_out, 16'h0000);
    check("r_rdat", rdat, 16'h0000);
    check("r_errs", {err_tmo, err_phase}, 2'b00);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("r_idle_after", {vma, ack}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
